// File: rtl/loader_write_queue.sv
// Write queue between the game loader and SDRAM: buffers loader byte writes and
// issues them one per 4-cycle memory slot (the slot_phase==3 cycle ends each slot).
module loader_write_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int ADDR_W     = 22
) (
  input  logic                  clock,
  input  logic                  R_reset,
  input  logic                  wr_strobe,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [1:0]            slot_phase,
  input  logic                  load_done,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_din,
  output logic [DEPTH_LOG2:0]   pending,
  output logic                  full,
  output logic                  overflow,
  output logic                  drained
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state;
  logic [ADDR_W+7:0]       fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   head;
  logic [DEPTH_LOG2-1:0]   tail;
  logic [DEPTH_LOG2:0]     count;

  logic slot;
  logic pop;
  logic req;
  logic push;
  logic drop;

  // Pop decision uses the pre-push occupancy, so a write landing in an empty
  // queue during the slot cycle waits for the next slot.
  assign slot = (slot_phase == 2'd3);
  assign pop  = slot && (count != '0);
  assign req  = wr_strobe && !load_done;
  assign push = req && (!full || pop);
  assign drop = req && full && !pop;

  assign full    = (count == CNT_DEPTH);
  assign pending = count;
  assign mem_we  = (state == ISSUE);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[tail] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clock) begin
    if (R_reset) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_din  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drained  <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
      // Issue outputs move only at the end of a slot, so each write is held 4 cycles.
      if (slot) begin
        if (count != '0) begin
          state               <= ISSUE;
          {mem_addr, mem_din} <= fifo_mem[head];
        end else begin
          state <= IDLE;
        end
      end
      drained <= load_done && (count == '0) && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_loader_write_queue.sv
// Directed bench for loader_write_queue: slot_phase is driven by the bench,
// either frozen or free-running, so every expected value is fixed by the step sequence.
module tb_loader_write_queue;

  logic        clock = 1'b0;
  logic        R_reset;
  logic        wr_strobe;
  logic [21:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  slot_phase;
  logic        load_done;
  logic        mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic [3:0]  pending;
  logic        full;
  logic        overflow;
  logic        drained;

  int checks   = 0;
  int failures = 0;
  logic ph_run = 1'b0;

  loader_write_queue #(.DEPTH_LOG2(3), .ADDR_W(22)) dut (
    .clock      (clock),
    .R_reset    (R_reset),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .slot_phase (slot_phase),
    .load_done  (load_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .pending    (pending),
    .full       (full),
    .overflow   (overflow),
    .drained    (drained)
  );

  always #5 clock = ~clock;

  // One clock: inputs and checks settle 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (ph_run) slot_phase = slot_phase + 2'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [21:0] a, input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    cyc();
    wr_strobe = 1'b0;
  endtask

  initial begin
    R_reset = 1'b1; wr_strobe = 1'b0; wr_addr = '0; wr_data = '0;
    slot_phase = 2'd0; load_done = 1'b0;
    cyc(); cyc();
    R_reset = 1'b0;
    chk("rst_we", mem_we, 0);
    chk("rst_pending", pending, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drained", drained, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);

    // Single write pushed at phase 0, issued at the following phase-3 edge.
    ph_run = 1'b1;
    push(22'h000010, 8'hA5);
    chk("single_pend1", pending, 1);
    chk("single_we0", mem_we, 0);
    cyc(); cyc();
    chk("single_we_wait", mem_we, 0);
    cyc();
    chk("single_we1", mem_we, 1);
    chk("single_addr", mem_addr, 22'h000010);
    chk("single_din", mem_din, 8'hA5);
    chk("single_pend0", pending, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("single_hold", mem_we, 1);
    end
    cyc();
    chk("single_end", mem_we, 0);
    chk("single_addr_hold", mem_addr, 22'h000010);
    chk("single_din_hold", mem_din, 8'hA5);

    // Burst of 8 with slot_phase frozen at 0: fills the queue.
    ph_run = 1'b0;
    slot_phase = 2'd0;
    for (int i = 0; i < 8; i++) push(22'h100 + 22'(i), 8'(i));
    chk("burst_full", full, 1);
    chk("burst_ovf", overflow, 0);
    chk("burst_pend", pending, 8);
    ph_run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); cyc(); cyc(); cyc();
      chk("burst_we", mem_we, 1);
      chk("burst_din", mem_din, 32'(i));
      chk("burst_addr", mem_addr, 32'h100 + 32'(i));
      chk("burst_pend_dec", pending, 32'(7 - i));
    end
    chk("burst_notfull", full, 0);
    cyc(); cyc(); cyc(); cyc();
    chk("burst_idle", mem_we, 0);

    // Refill, then push at full in the same cycle as a phase-3 pop.
    ph_run = 1'b0;
    slot_phase = 2'd0;
    for (int i = 0; i < 8; i++) push(22'h200 + 22'(i), 8'h10 + 8'(i));
    chk("fill_full", full, 1);
    slot_phase = 2'd3;
    push(22'h2FF, 8'h99);
    chk("popush_pend", pending, 8);
    chk("popush_full", full, 1);
    chk("popush_ovf", overflow, 0);
    chk("popush_we", mem_we, 1);
    chk("popush_din", mem_din, 8'h10);
    chk("popush_addr", mem_addr, 22'h200);

    // Push at full with no slot: dropped, overflow sticky.
    slot_phase = 2'd0;
    push(22'h3FF, 8'h77);
    chk("ovf_set", overflow, 1);
    chk("ovf_pend", pending, 8);
    cyc();
    chk("ovf_sticky", overflow, 1);

    // Drain three slots to reach 5 pending while a write is in progress.
    ph_run = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc(); cyc(); cyc(); cyc();
      chk("mid_din", mem_din, 32'h10 + 32'(i));
    end
    chk("mid_pend", pending, 5);
    chk("mid_we", mem_we, 1);

    // Reset mid-operation, with a simultaneous write request.
    R_reset = 1'b1;
    push(22'h055, 8'h55);
    R_reset = 1'b0;
    chk("mrst_we", mem_we, 0);
    chk("mrst_pend", pending, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_addr", mem_addr, 0);
    for (int k = 0; k < 8; k++) cyc();
    chk("mrst_quiet_we", mem_we, 0);
    chk("mrst_quiet_pend", pending, 0);

    // load_done with 3 entries pending: they drain, new request ignored.
    ph_run = 1'b0;
    slot_phase = 2'd0;
    for (int i = 0; i < 3; i++) push(22'h300 + 22'(i), 8'h30 + 8'(i));
    load_done = 1'b1;
    push(22'h3AA, 8'hAA);
    chk("ld_pend", pending, 3);
    chk("ld_ovf", overflow, 0);
    chk("ld_drained0", drained, 0);
    ph_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); cyc(); cyc(); cyc();
      chk("ld_din", mem_din, 32'h30 + 32'(i));
      chk("ld_drained_busy", drained, 0);
    end
    cyc(); cyc(); cyc(); cyc();
    chk("ld_we_end", mem_we, 0);
    chk("ld_din_last", mem_din, 8'h32);
    chk("ld_drained_edge", drained, 0);
    cyc();
    chk("ld_drained1", drained, 1);
    chk("ld_pend0", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
